// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Sequential PC fetch stage with credit-limited memory requests,
//               prefetch FIFO and single-cycle redirect with stale-drop.
// Revision    : 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int             c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(DEPTH);

    logic [31:0]        r_fetch_pc;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_drop_cnt;
    logic [c_PTR_W-1:0] r_fifo_rd;
    logic [c_PTR_W-1:0] r_fifo_wr;
    logic [c_PTR_W-1:0] r_pq_rd;
    logic [c_PTR_W-1:0] r_pq_wr;
    logic [31:0]        r_fifo_pc    [DEPTH];
    logic [31:0]        r_fifo_instr [DEPTH];
    logic [31:0]        r_pq         [DEPTH];

    logic [c_CNT_W:0]   w_credit_sum;
    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_draining;
    logic               w_push;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_outstanding_nxt;
    logic               w_unused;

    // Every request in flight owns a FIFO slot, so a response can never overflow.
    assign w_credit_sum      = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_req_valid       = rst && (w_credit_sum < c_DEPTH) && !redirect_valid;
    assign w_req_fire        = w_req_valid && imem_req_ready;
    assign w_draining        = (r_drop_cnt != '0);
    assign w_push            = imem_rsp_valid && !w_draining && !redirect_valid;
    assign w_pop             = (r_count != '0) && if_ready;
    assign w_outstanding_nxt = r_outstanding + c_CNT_W'(w_req_fire) - c_CNT_W'(imem_rsp_valid);
    assign w_unused          = &{1'b0, redirect_pc[1:0], r_pq[r_pq_rd]};

    assign imem_req_valid = w_req_valid;
    assign imem_addr      = r_fetch_pc;
    assign if_valid       = (r_count != '0);
    assign if_instr       = r_fifo_instr[r_fifo_rd];
    assign if_pc          = r_fifo_pc[r_fifo_rd];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_fifo_rd     <= '0;
            r_fifo_wr     <= '0;
            r_pq_rd       <= '0;
            r_pq_wr       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_pc[i]    <= '0;
                r_fifo_instr[i] <= '0;
                r_pq[i]         <= '0;
            end
        end else begin
            r_outstanding <= w_outstanding_nxt;

            // The pc queue tracks every accepted request regardless of redirects.
            if (w_req_fire) begin
                r_fetch_pc     <= r_fetch_pc + 32'd4;
                r_pq[r_pq_wr]  <= r_fetch_pc;
                r_pq_wr        <= r_pq_wr + 1'b1;
            end
            if (imem_rsp_valid) begin
                r_pq_rd <= r_pq_rd + 1'b1;
            end

            if (redirect_valid) begin
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
                r_count    <= '0;
                r_fifo_rd  <= '0;
                r_fifo_wr  <= '0;
                r_drop_cnt <= w_outstanding_nxt;
            end else begin
                if (imem_rsp_valid && w_draining) begin
                    r_drop_cnt <= r_drop_cnt - 1'b1;
                end
                if (w_push) begin
                    r_fifo_pc[r_fifo_wr]    <= r_pq[r_pq_rd];
                    r_fifo_instr[r_fifo_wr] <= imem_rsp_data;
                    r_fifo_wr               <= r_fifo_wr + 1'b1;
                end
                if (w_pop) begin
                    r_fifo_rd <= r_fifo_rd + 1'b1;
                end
                r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench with an in-order memory model.
// Revision    : 1.0
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          mem_lat  = 1;
    int          cyc      = 0;
    int          req_cnt  = 0;
    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    logic [31:0] consumed [$];

    instr_fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory drives responses at the start of a cycle, then records handshakes once inputs settle.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            mq_addr.delete();
            mq_due.delete();
            imem_rsp_valid = 1'b0;
        end else if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq_addr[0] ^ 32'hA5A5_A5A5;
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
        end
        #2;
        if (!rst) begin
            mq_addr.delete();
            mq_due.delete();
            imem_rsp_valid = 1'b0;
            req_cnt        = 0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                mq_addr.push_back(imem_addr);
                mq_due.push_back(cyc + mem_lat);
                req_cnt++;
            end
            if (if_valid && if_ready) begin
                consumed.push_back(if_pc);
                chk("instr_vs_pc", if_instr, if_pc ^ 32'hA5A5_A5A5);
            end
        end
    end

    task automatic do_reset(input int lat, input logic rdy);
        @(negedge clk);
        rst            = 1'b0;
        mem_lat        = lat;
        if_ready       = rdy;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        consumed.delete();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid, 32'd0);
        chk("rst_addr",      imem_addr,      32'h0);
        chk("rst_if_valid",  if_valid,       32'd0);
        chk("rst_if_instr",  if_instr,       32'h0);
        chk("rst_if_pc",     if_pc,          32'h0);

        // Streaming with 1-cycle memory
        do_reset(1, 1'b1);
        chk("t1_req_valid_c0", imem_req_valid, 32'd1);
        chk("t1_addr_c0",      imem_addr,      32'h0);
        chk("t1_if_valid_c0",  if_valid,       32'd0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            #1;
            chk("t1_addr", imem_addr, 32'(k * 4));
            chk("t1_if_valid", if_valid, {31'd0, (k >= 2)});
            if (k >= 2) chk("t1_if_pc", if_pc, 32'((k - 2) * 4));
        end

        // Back-pressure: credit caps issued requests at DEPTH
        do_reset(1, 1'b0);
        repeat (10) @(negedge clk);
        #1;
        chk("t2_req_cnt",   req_cnt,        32'd4);
        chk("t2_req_valid", imem_req_valid, 32'd0);
        chk("t2_if_valid",  if_valid,       32'd1);
        chk("t2_if_pc",     if_pc,          32'h0);
        chk("t2_if_instr",  if_instr,       32'hA5A5_A5A5);
        @(negedge clk);
        if_ready = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("t2_n_consumed", {31'd0, (consumed.size() >= 5)}, 32'd1);
        for (int i = 0; i < 5; i++) chk("t2_seq", consumed[i], 32'(i * 4));

        // Redirect with 3 stale requests in flight (3-cycle memory)
        do_reset(3, 1'b1);
        repeat (2) @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        #1;
        chk("t3_req_blocked", imem_req_valid, 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("t3_if_valid_n1", if_valid,       32'd0);
        chk("t3_req_valid",   imem_req_valid, 32'd1);
        chk("t3_addr",        imem_addr,      32'h0000_0100);
        repeat (8) @(negedge clk);
        #1;
        chk("t3_first", consumed[0], 32'h0000_0100);
        chk("t3_second", consumed[1], 32'h0000_0104);
        chk("t3_third", consumed[2], 32'h0000_0108);

        // Redirect coinciding with decode handshake of pc 0x8
        do_reset(1, 1'b1);
        repeat (3) @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0202;
        #1;
        chk("t4_if_valid_hs", if_valid, 32'd1);
        chk("t4_if_pc_hs",    if_pc,    32'h8);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("t4_if_valid_n1", if_valid,  32'd0);
        chk("t4_addr",        imem_addr, 32'h0000_0200);
        @(negedge clk);
        #1;
        chk("t4_if_valid_n2", if_valid, 32'd0);
        @(negedge clk);
        #1;
        chk("t4_if_valid_n3", if_valid, 32'd1);
        chk("t4_if_pc_n3",    if_pc,    32'h0000_0200);
        repeat (2) @(negedge clk);
        #1;
        chk("t4_n_consumed", consumed.size(), 32'd5);
        chk("t4_c2", consumed[2], 32'h8);
        chk("t4_c3", consumed[3], 32'h0000_0200);
        chk("t4_c4", consumed[4], 32'h0000_0204);

        // PC wrap at the top of the address space
        do_reset(1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        chk("t5_addr_wrap",  imem_addr,      32'h0);
        chk("t5_req_valid",  imem_req_valid, 32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("t5_top_consumed",  consumed[1], 32'hFFFF_FFFC);
        chk("t5_wrap_consumed", consumed[2], 32'h0);

        // Asynchronous reset with a full FIFO
        do_reset(1, 1'b0);
        repeat (8) @(negedge clk);
        #1;
        chk("t6_full_valid", if_valid,       32'd1);
        chk("t6_full_noreq", imem_req_valid, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_if_valid",  if_valid,       32'd0);
        chk("t6_req_valid", imem_req_valid, 32'd0);
        chk("t6_if_pc",     if_pc,          32'h0);
        chk("t6_if_instr",  if_instr,       32'h0);
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        if_ready = 1'b1;
        consumed.delete();
        #1;
        chk("t6_rel_req_valid", imem_req_valid, 32'd1);
        chk("t6_rel_addr",      imem_addr,      32'h0);
        repeat (4) @(negedge clk);
        #1;
        chk("t6_c0", consumed[0], 32'h0);
        chk("t6_c1", consumed[1], 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
